// File: rtl/bitop_pkg.sv
// Shared definitions for the bitwise-operation pipeline: op encoding and widths.
package bitop_pkg;

   localparam int unsigned OP_W    = 2;
   localparam int unsigned COUNT_W = 16;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 2'd0,
      OP_OR   = 2'd1,
      OP_XOR  = 2'd2,
      OP_NAND = 2'd3
   } op_t;

endpackage

// File: rtl/bitop_stage.sv
// One pipeline register: valid bit plus data word, loaded only when enabled.
module bitop_stage #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             d_valid,
   input  logic [WIDTH-1:0] d_data,
   output logic             q_valid,
   output logic [WIDTH-1:0] q_data
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_valid <= 1'b0;
         q_data  <= '0;
      end else if (en) begin
         q_valid <= d_valid;
         q_data  <= d_data;
      end
   end

endmodule

// File: rtl/bitop_pipe.sv
// Bitwise AND/OR/XOR/NAND pipeline with valid/ready handshake and delivered-beat counter.
module bitop_pipe
   import bitop_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in1,
   input  logic [WIDTH-1:0]   in2,
   input  logic [OP_W-1:0]    op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out,
   output logic [COUNT_W-1:0] ops_done
);

   logic             valid [STAGES+1];
   logic [WIDTH-1:0] data  [STAGES+1];
   logic [WIDTH-1:0] result;
   logic             stall;
   logic             advance;

   // Operation is resolved before the first register; later stages only carry data.
   always_comb begin
      result = '0;
      case (op_t'(op))
         OP_AND:  result = in1 & in2;
         OP_OR:   result = in1 | in2;
         OP_XOR:  result = in1 ^ in2;
         OP_NAND: result = ~(in1 & in2);
         default: result = '0;
      endcase
   end

   assign valid[0] = in_valid;
   assign data[0]  = result;

   // A held output freezes the whole pipe, so ready only depends on output state.
   assign stall    = out_valid && !out_ready;
   assign advance  = !stall;
   assign in_ready = !stall;

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      bitop_stage #(.WIDTH(WIDTH)) u_stage (
         .clk     (clk),
         .rst     (rst),
         .en      (advance),
         .d_valid (valid[i]),
         .d_data  (data[i]),
         .q_valid (valid[i+1]),
         .q_data  (data[i+1])
      );
   end

   assign out_valid = valid[STAGES];
   assign out       = data[STAGES];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ops_done <= '0;
      end else if (out_valid && out_ready) begin
         ops_done <= ops_done + COUNT_W'(1);
      end
   end

endmodule

// File: tb/tb_bitop_pipe.sv
// Bench for bitop_pipe: 8-bit/2-stage directed cases plus 32-bit/4-stage random traffic.
module tb_bitop_pipe;
   import bitop_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   logic        iv8, ir8, ov8, or8;
   logic [7:0]  a8, b8, o8;
   logic [1:0]  op8;
   logic [15:0] od8;

   logic        iv32, ir32, ov32, or32;
   logic [31:0] a32, b32, o32;
   logic [1:0]  op32;
   logic [15:0] od32;

   bitop_pipe #(.WIDTH(8), .STAGES(2)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in1(a8), .in2(b8), .op(op8),
      .out_valid(ov8), .out_ready(or8), .out(o8), .ops_done(od8)
   );

   bitop_pipe #(.WIDTH(32), .STAGES(4)) dut32 (
      .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .in1(a32), .in2(b32), .op(op32),
      .out_valid(ov32), .out_ready(or32), .out(o32), .ops_done(od32)
   );

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  q8  [$];
   logic [31:0] q32 [$];
   logic [15:0] ops8  = '0;
   logic [15:0] ops32 = '0;
   int          del_n8 = 0, del_n32 = 0, acc_n32 = 0;

   // Reference: bitwise result of the selected operation, truncated to w bits.
   function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                         input logic [1:0] o, input int w);
      logic [63:0] r;
      logic [63:0] mask;
      mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      case (o)
         2'd0:    r = a & b;
         2'd1:    r = a | b;
         2'd2:    r = a ^ b;
         default: r = ~(a & b);
      endcase
      return r & mask;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: inputs were set at the negedge; decide handshakes, score, advance.
   task automatic tick(output bit acc8);
      bit d8, acc32, d32;
      #1;
      acc8  = iv8 && ir8;
      d8    = ov8 && or8;
      acc32 = iv32 && ir32;
      d32   = ov32 && or32;
      if (d8) begin
         if (q8.size() == 0) chk("spurious8", 64'(q8.size()), 64'd1);
         else                chk("out8", 64'(o8), 64'(q8.pop_front()));
         ops8++;
         del_n8++;
      end
      if (acc8) q8.push_back(8'(model(64'(a8), 64'(b8), op8, 8)));
      if (d32) begin
         if (q32.size() == 0) chk("spurious32", 64'(q32.size()), 64'd1);
         else                 chk("out32", 64'(o32), 64'(q32.pop_front()));
         ops32++;
         del_n32++;
      end
      if (acc32) begin
         q32.push_back(32'(model(64'(a32), 64'(b32), op32, 32)));
         acc_n32++;
      end
      @(posedge clk);
      @(negedge clk);
      chk("ops_done8", 64'(od8), 64'(ops8));
      chk("ops_done32", 64'(od32), 64'(ops32));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_ov8", 64'(ov8), 64'd0);
      chk("rst_o8", 64'(o8), 64'd0);
      chk("rst_od8", 64'(od8), 64'd0);
      chk("rst_ov32", 64'(ov32), 64'd0);
      chk("rst_od32", 64'(od32), 64'd0);
      q8.delete();
      q32.delete();
      ops8  = '0;
      ops32 = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bit          acc;
      int          idx, start, base_del, guard;
      logic [7:0]  sa [4];
      logic [7:0]  sb [4];
      logic [7:0]  held;

      iv8 = 0; a8 = '0; b8 = '0; op8 = '0; or8 = 1'b1;
      iv32 = 0; a32 = '0; b32 = '0; op32 = '0; or32 = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      do_reset();
      #1;
      chk("idle_ir8", 64'(ir8), 64'd1);
      chk("idle_ir32", 64'(ir32), 64'd1);
      @(negedge clk);

      // Single AND beat: visible exactly two edges after the accepting one counts as one.
      iv8 = 1; a8 = 8'd29; b8 = 8'd95; op8 = 2'd0;
      tick(acc);
      chk("lat_accept", 64'(acc), 64'd1);
      iv8 = 0;
      chk("lat_early", 64'(ov8), 64'd0);
      tick(acc);
      chk("lat_valid", 64'(ov8), 64'd1);
      chk("lat_and", 64'(o8), 64'd29);
      tick(acc);

      // Back-to-back OR, XOR, NAND.
      start = int'(ops8);
      iv8 = 1; op8 = 2'd1;
      tick(acc);
      op8 = 2'd2;
      tick(acc);
      chk("seq_or", 64'(o8), 64'd95);
      op8 = 2'd3;
      tick(acc);
      chk("seq_xor", 64'(o8), 64'd66);
      iv8 = 0;
      tick(acc);
      chk("seq_nand", 64'(o8), 64'd226);
      tick(acc);
      tick(acc);
      chk("seq_count", 64'(od8), 64'(16'(start + 3)));

      // Stall: out_ready low for 5 cycles while 4 beats are offered.
      for (int k = 0; k < 4; k++) begin
         sa[k] = 8'($urandom);
         sb[k] = 8'($urandom);
      end
      base_del = del_n8;
      idx = 0;
      or8 = 0;
      held = 8'(model(64'(sa[0]), 64'(sb[0]), 2'd0, 8));
      for (int c = 0; c < 5; c++) begin
         iv8 = (idx < 4); a8 = sa[idx % 4]; b8 = sb[idx % 4]; op8 = 2'(idx % 4);
         tick(acc);
         if (acc) idx++;
         if (c >= 1) begin
            chk("stall_ov", 64'(ov8), 64'd1);
            chk("stall_out", 64'(o8), 64'(held));
            chk("stall_ir", 64'(ir8), 64'd0);
         end
      end
      or8 = 1;
      guard = 0;
      while (idx < 4 && guard < 20) begin
         iv8 = 1; a8 = sa[idx]; b8 = sb[idx]; op8 = 2'(idx);
         tick(acc);
         if (acc) idx++;
         guard++;
      end
      iv8 = 0;
      for (int c = 0; c < 6; c++) tick(acc);
      chk("stall_delivered", 64'(del_n8 - base_del), 64'd4);
      chk("stall_empty", 64'(q8.size()), 64'd0);

      // Reset with two beats in flight.
      or8 = 0;
      iv8 = 1; a8 = 8'h5a; b8 = 8'h3c; op8 = 2'd2;
      tick(acc);
      op8 = 2'd1;
      tick(acc);
      iv8 = 0;
      do_reset();
      iv8 = 1; or8 = 1; a8 = 8'hf0; b8 = 8'h33; op8 = 2'd3;
      tick(acc);
      chk("first_after_rst", 64'(acc), 64'd1);
      iv8 = 0;
      for (int c = 0; c < 5; c++) tick(acc);
      chk("rst_delivered", 64'(ops8), 64'd1);
      chk("rst_empty", 64'(q8.size()), 64'd0);

      // Random 32-bit traffic with random valid/ready.
      for (int c = 0; c < 2000; c++) begin
         iv32 = ($urandom_range(0, 3) != 0);
         a32  = $urandom;
         b32  = $urandom;
         op32 = 2'($urandom_range(0, 3));
         or32 = ($urandom_range(0, 3) != 0);
         tick(acc);
      end
      iv32 = 0; or32 = 1;
      for (int c = 0; c < 8; c++) tick(acc);
      chk("r32_empty", 64'(q32.size()), 64'd0);
      chk("r32_inorder_count", 64'(del_n32), 64'(acc_n32));

      // Counter wrap after 65537 deliveries.
      do_reset();
      del_n8 = 0;
      idx = 0;
      or8 = 1;
      guard = 0;
      while (del_n8 < 65537 && guard < 70000) begin
         iv8 = (idx < 65537);
         a8 = 8'($urandom); b8 = 8'($urandom); op8 = 2'($urandom_range(0, 3));
         tick(acc);
         if (acc) idx++;
         guard++;
      end
      iv8 = 0;
      chk("wrap_delivered", 64'(del_n8), 64'd65537);
      chk("wrap_ops_done", 64'(od8), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bitop_pipe.md
BITOP_PIPE -- requirements
Module: bitop_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal 1..64).
REQ-002 SHALL have parameter STAGES, default 2, register stages input->output (legal 1..4).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand beat offered.
REQ-006 SHALL have port in_ready  output  1  block accepts operand beat this cycle.
REQ-007 SHALL have port in1  input  WIDTH  first operand.
REQ-008 SHALL have port in2  input  WIDTH  second operand.
REQ-009 SHALL have port op  input  2  operation select, sampled with the beat: 0 AND, 1 OR, 2 XOR, 3 NAND.
REQ-010 SHALL have port out_valid  output  1  result beat presented.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port out  output  WIDTH  result data.
REQ-013 SHALL have port ops_done  output  16  count of result beats delivered.

Function
REQ-014 SHALL accept a beat when in_valid && in_ready are both high on a posedge clk.
REQ-015 SHALL deliver a result beat when out_valid && out_ready are both high on a posedge clk.
REQ-016 SHALL compute the op result bitwise over WIDTH bits in stage 1; later stages carry the data unchanged.
REQ-017 SHALL give an accepted beat a latency of exactly STAGES cycles to out_valid when no stall occurs.
REQ-018 SHALL define stall = out_valid && !out_ready; while stall is high, no stage register changes.
REQ-019 SHALL drive in_ready = !stall (combinational); no combinational path from in_valid to in_ready.
REQ-020 SHALL, when not stalled, advance every stage, and stage 1 loads valid = in_valid.
REQ-021 SHALL keep out and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL sustain one beat per cycle with out_ready held high (full throughput, no bubbles inserted).
REQ-023 SHALL let empty stages fill while the output is not stalled (bubble collapse not required).
REQ-024 SHALL pass back-to-back beats with differing op values, each producing its own op's result in order.
REQ-025 SHALL increment ops_done by 1 per delivered beat, wrapping from 65535 to 0.
REQ-026 SHALL treat a simultaneous accept and deliver in one cycle as both taking effect.
REQ-027 SHALL drive out to the data register value even when out_valid is 0; consumers ignore it.

Reset
REQ-028 SHALL, on rst high, clear all stage valid bits, drive out_valid 0, drive out 0, and drive ops_done 0, asynchronously.
REQ-029 SHALL drive in_ready 1 while rst is low and the pipeline is empty after reset.
REQ-030 SHALL discard in-flight beats when reset is asserted mid-operation; no result from them ever appears.
REQ-031 SHALL release reset without a partial beat, and accept a beat on the first posedge after deassertion.

Structure
REQ-032 SHALL take the op encoding constants (OP_AND, OP_OR, OP_XOR, OP_NAND) and the op typedef from shared package bitop_pkg.
REQ-033 SHALL implement one sub-module, bitop_stage, as a parametrised valid+data register with enable and async reset.
REQ-034 SHALL instantiate bitop_stage STAGES times via generate.
REQ-035 SHALL contain no latches, and no logic on clk other than the edge.

Verification
REQ-036 SHALL cover: WIDTH=8, STAGES=2; a=29, b=95, op=AND, out_ready=1 -> out=29 with out_valid exactly 2 cycles after accept.
REQ-037 SHALL cover: the same operands with op OR, then XOR, then NAND back-to-back -> out sequence 95, 66, 226 on consecutive cycles, with ops_done advancing by 3.
REQ-038 SHALL cover: out_ready held low for 5 cycles with 4 beats offered -> in_ready=0 during stall, out held, no beat lost or duplicated after release.
REQ-039 SHALL cover: rst asserted while 2 beats are in flight -> out_valid=0 and ops_done=0 immediately, and no stale result after release.
REQ-040 SHALL cover: 65537 delivered beats -> ops_done reads 1.
REQ-041 SHALL cover: WIDTH=32, STAGES=4, random ops against a reference model, with random in_valid/out_ready -> results match in order.
